// File: rtl/rst_sequencer.sv
// Central reset sequencer: pulses the PLL reset, waits for a stable lock with
// timeout and bounded retry, then releases downstream reset domains in order.
module rst_sequencer #(
  parameter int PLL_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int LOCK_STABLE    = 16,
  parameter int NUM_STAGES     = 3,
  parameter int STAGE_DELAY    = 100,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  soft_rst,
  input  logic                  fault_clr,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  ready,
  output logic                  fault,
  output logic [3:0]            retry_cnt
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE           = CNT_W'(1);
  localparam logic [CNT_W-1:0] PLL_RST_LAST      = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] STAGE_DELAY_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_ONE           = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST          = IDX_W'(NUM_STAGES - 1);
  localparam logic [3:0]       RETRY_LIMIT       = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t                  state_r, state_nxt;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt;
  logic [IDX_W-1:0]        idx_r, idx_nxt;
  logic [3:0]              retry_r, retry_nxt;
  logic                    pll_rst_r, pll_rst_nxt;
  logic [NUM_STAGES-1:0]   stage_r, stage_nxt;
  logic                    ready_r, ready_nxt;
  logic                    fault_r, fault_nxt;
  logic [1:0]              lock_sync_r;
  logic                    lock_s;
  logic                    restart_req_s;
  logic                    restart_s;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    if (v == 4'hF) begin
      return 4'hF;
    end else begin
      return v + 4'd1;
    end
  endfunction

  // Two-flop synchroniser for the asynchronous PLL lock input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_r <= 2'b00;
    end else begin
      lock_sync_r <= {lock_sync_r[0], pll_locked};
    end
  end

  assign lock_s = lock_sync_r[1];

  // Lock loss only matters once domains are being released; FAULT ignores both sources
  assign restart_req_s = soft_rst |
                         (~lock_s & ((state_r == ST_RELEASE) | (state_r == ST_RUN)));

  // Next-state and next-output logic for the sequencing FSM
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    idx_nxt     = idx_r;
    retry_nxt   = retry_r;
    pll_rst_nxt = pll_rst_r;
    stage_nxt   = stage_r;
    ready_nxt   = ready_r;
    fault_nxt   = fault_r;
    restart_s   = 1'b0;

    if ((state_r != ST_FAULT) && restart_req_s) begin
      restart_s = 1'b1;
    end else begin
      case (state_r)
        ST_PLL_RST: begin
          pll_rst_nxt = 1'b1;
          if (cnt_r == PLL_RST_LAST) begin
            state_nxt   = ST_WAIT_LOCK;
            cnt_nxt     = '0;
            pll_rst_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = '0;
          end else if (cnt_r == LOCK_TIMEOUT_LAST) begin
            cnt_nxt = '0;
            if (retry_r == RETRY_LIMIT) begin
              state_nxt   = ST_FAULT;
              fault_nxt   = 1'b1;
              pll_rst_nxt = 1'b0;
              stage_nxt   = '0;
              ready_nxt   = 1'b0;
            end else begin
              state_nxt   = ST_PLL_RST;
              retry_nxt   = sat_inc4(retry_r);
              pll_rst_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt_r + CNT_ONE;
          end
        end
        ST_SETTLE: begin
          // A lock glitch here is not a timeout, so the retry budget is untouched
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt_r == LOCK_STABLE_LAST) begin
            state_nxt = ST_RELEASE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            cnt_nxt = cnt_r + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (cnt_r == STAGE_DELAY_LAST) begin
            cnt_nxt            = '0;
            stage_nxt[idx_r]   = 1'b1;
            if (idx_r == IDX_LAST) begin
              state_nxt = ST_RUN;
              ready_nxt = 1'b1;
            end else begin
              idx_nxt = idx_r + IDX_ONE;
            end
          end else begin
            cnt_nxt = cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          pll_rst_nxt = 1'b0;
          stage_nxt   = '1;
          ready_nxt   = 1'b1;
        end
        ST_FAULT: begin
          pll_rst_nxt = 1'b0;
          stage_nxt   = '0;
          ready_nxt   = 1'b0;
          fault_nxt   = 1'b1;
          if (fault_clr) begin
            state_nxt   = ST_PLL_RST;
            fault_nxt   = 1'b0;
            retry_nxt   = 4'd0;
            cnt_nxt     = '0;
            pll_rst_nxt = 1'b1;
          end else begin
            state_nxt = ST_FAULT;
          end
        end
        default: begin
          restart_s = 1'b1;
        end
      endcase
    end

    if (restart_s) begin
      state_nxt   = ST_PLL_RST;
      cnt_nxt     = '0;
      idx_nxt     = '0;
      retry_nxt   = 4'd0;
      pll_rst_nxt = 1'b1;
      stage_nxt   = '0;
      ready_nxt   = 1'b0;
      fault_nxt   = 1'b0;
    end else begin
      state_nxt = state_nxt;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_PLL_RST;
      cnt_r     <= '0;
      idx_r     <= '0;
      retry_r   <= 4'd0;
      pll_rst_r <= 1'b1;
      stage_r   <= '0;
      ready_r   <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      idx_r     <= idx_nxt;
      retry_r   <= retry_nxt;
      pll_rst_r <= pll_rst_nxt;
      stage_r   <= stage_nxt;
      ready_r   <= ready_nxt;
      fault_r   <= fault_nxt;
    end
  end

  assign pll_rst     = pll_rst_r;
  assign stage_rst_n = stage_r;
  assign ready       = ready_r;
  assign fault       = fault_r;
  assign retry_cnt   = retry_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboarded bench for rst_sequencer: a phase/countdown reference model pushes
// expected outputs per clock, a monitor pops and compares; directed timing checks on top.
module tb_rst_sequencer;

  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 1024;
  localparam int LOCK_STABLE    = 16;
  localparam int NUM_STAGES     = 3;
  localparam int STAGE_DELAY    = 100;
  localparam int MAX_RETRY      = 3;

  // Edges from sequence start (PLL_RST cnt=0) to entering SETTLE when already locked
  localparam int SETTLE_AT = PLL_RST_CYCLES + 1;
  localparam int FAULT_AT  = (MAX_RETRY + 1) * (PLL_RST_CYCLES + LOCK_TIMEOUT);

  localparam int P_PULSE = 0, P_WAIT = 1, P_SETTLE = 2, P_RELEASE = 3, P_RUN = 4, P_FAULT = 5;

  typedef logic [9:0] obs_t;  // {pll_rst, stage_rst_n[2:0], ready, fault, retry_cnt[3:0]}
  localparam obs_t RESET_OBS = 10'b1_000_0_0_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic       fault_clr = 1'b0;
  logic       pll_rst;
  logic [2:0] stage_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int t_edges = 0;

  obs_t exp_q[$];

  int   m_phase, m_left, m_released, m_timeouts;
  logic m_s1, m_s2;

  always #5 clk = ~clk;

  rst_sequencer #(
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .LOCK_STABLE   (LOCK_STABLE),
    .NUM_STAGES    (NUM_STAGES),
    .STAGE_DELAY   (STAGE_DELAY),
    .MAX_RETRY     (MAX_RETRY),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .soft_rst   (soft_rst),
    .fault_clr  (fault_clr),
    .pll_rst    (pll_rst),
    .stage_rst_n(stage_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_start_pulse();
    m_phase    = P_PULSE;
    m_left     = PLL_RST_CYCLES;
    m_released = 0;
  endtask

  task automatic m_reset();
    m_start_pulse();
    m_timeouts = 0;
    m_s1 = 1'b0;
    m_s2 = 1'b0;
  endtask

  function automatic obs_t m_outputs();
    logic [2:0] mask;
    mask = 3'((1 << m_released) - 1);
    if (m_phase == P_RUN) mask = 3'b111;
    else if (m_phase != P_RELEASE) mask = 3'b000;
    return {m_phase == P_PULSE, mask, m_phase == P_RUN, m_phase == P_FAULT, 4'(m_timeouts)};
  endfunction

  task automatic m_step(input logic srst, input logic fclr, input logic lk);
    logic locked;
    locked = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    if (m_phase != P_FAULT &&
        (srst || (!locked && (m_phase == P_RELEASE || m_phase == P_RUN)))) begin
      m_start_pulse();
      m_timeouts = 0;
    end else begin
      case (m_phase)
        P_PULSE: begin
          m_left--;
          if (m_left == 0) begin m_phase = P_WAIT; m_left = LOCK_TIMEOUT; end
        end
        P_WAIT: begin
          if (locked) begin
            m_phase = P_SETTLE; m_left = LOCK_STABLE;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (m_timeouts == MAX_RETRY) m_phase = P_FAULT;
              else begin
                m_timeouts = (m_timeouts < 15) ? m_timeouts + 1 : 15;
                m_start_pulse();
              end
            end
          end
        end
        P_SETTLE: begin
          if (!locked) begin
            m_phase = P_WAIT; m_left = LOCK_TIMEOUT;
          end else begin
            m_left--;
            if (m_left == 0) begin m_phase = P_RELEASE; m_left = STAGE_DELAY; m_released = 0; end
          end
        end
        P_RELEASE: begin
          m_left--;
          if (m_left == 0) begin
            m_released++;
            if (m_released == NUM_STAGES) m_phase = P_RUN;
            else m_left = STAGE_DELAY;
          end
        end
        P_RUN: ;
        P_FAULT: begin
          if (fclr) begin m_start_pulse(); m_timeouts = 0; end
        end
        default: m_reset();
      endcase
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) m_reset();
      else m_step(soft_rst, fault_clr, pll_locked);
      exp_q.push_back(m_outputs());
    end
  end

  // ---------------- monitor ----------------
  initial begin
    obs_t want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        if (!rst_n) want = RESET_OBS;
        check("outputs", 32'({pll_rst, stage_rst_n, ready, fault, retry_cnt}), 32'(want));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    t_edges++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t_edges = 0;
  endtask

  task automatic wait_stage(input logic [2:0] want, input int limit, input string name,
                            input int want_edge);
    while (stage_rst_n !== want && t_edges < limit) step();
    check(name, 32'(t_edges), 32'(want_edge));
  endtask

  initial begin
    int lvl, dur, r, total;

    // 1: locked from the start; reset values, pulse width, stage release timing
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({pll_rst, stage_rst_n, ready, fault, retry_cnt}), 32'(RESET_OBS));
    rst_n = 1'b1;
    t_edges = 0;
    while (pll_rst && t_edges < 50) step();
    check("t1_pll_rst_width", 32'(t_edges), 32'(PLL_RST_CYCLES));
    wait_stage(3'b001, 2000, "t1_stage0", SETTLE_AT + LOCK_STABLE + 1 * STAGE_DELAY);
    wait_stage(3'b011, 2000, "t1_stage1", SETTLE_AT + LOCK_STABLE + 2 * STAGE_DELAY);
    wait_stage(3'b111, 2000, "t1_stage2", SETTLE_AT + LOCK_STABLE + 3 * STAGE_DELAY);
    check("t1_ready", 32'(ready), 32'd1);

    // 4: lock loss in RUN restarts within three edges, then a full re-sequence
    pll_locked = 1'b0;
    repeat (3) step();
    check("t4_restart", 32'({pll_rst, stage_rst_n, ready, retry_cnt}), 32'(9'b1_000_0_0000));
    pll_locked = 1'b1;
    t_edges = 0;
    wait_stage(3'b111, 2000, "t4_resequence", SETTLE_AT + LOCK_STABLE + 3 * STAGE_DELAY);

    // 3: three-cycle lock glitch mid-SETTLE
    pll_locked = 1'b0;
    repeat (12) step();
    pll_locked = 1'b1;
    repeat (8) step();
    pll_locked = 1'b0;
    repeat (3) step();
    check("t3_retry_zero", 32'(retry_cnt), 32'd0);
    pll_locked = 1'b1;
    t_edges = 0;
    wait_stage(3'b001, 2000, "t3_settle_full", 3 + LOCK_STABLE + STAGE_DELAY);

    // 5: soft_rst and lock loss seen on the same edge during RELEASE (idx=1)
    repeat (20) step();
    pll_locked = 1'b0;
    repeat (2) step();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    check("t5_single_restart", 32'({pll_rst, stage_rst_n, ready, retry_cnt}), 32'(9'b1_000_0_0000));
    // 2: no lock at all -> FAULT after every attempt times out
    t_edges = 0;
    while (!fault && t_edges < FAULT_AT + 500) step();
    check("t2_fault_time", 32'(t_edges), 32'(FAULT_AT));
    check("t2_fault_retry", 32'(retry_cnt), 32'(MAX_RETRY));
    check("t2_fault_stages", 32'(stage_rst_n), 32'd0);
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    step();
    check("t5_soft_in_fault", 32'({fault, pll_rst}), 32'(2'b10));
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("t5_fault_clr", 32'({fault, pll_rst, retry_cnt}), 32'(6'b01_0000));

    // 6: asynchronous reset mid-RELEASE
    pll_locked = 1'b1;
    t_edges = 0;
    wait_stage(3'b001, 2000, "t6_pre", SETTLE_AT + LOCK_STABLE + STAGE_DELAY);
    repeat (10) step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("t6_async_reset", 32'({pll_rst, stage_rst_n, ready, fault, retry_cnt}), 32'(RESET_OBS));
    repeat (3) step();
    rst_n = 1'b1;

    // randomized segments checked by the scoreboard
    total = 0;
    while (total < 40000) begin
      lvl = ($urandom_range(0, 3) != 0) ? 1 : 0;
      r = $urandom_range(0, 9);
      if (r < 4) dur = $urandom_range(1, 20);
      else if (r < 8) dur = $urandom_range(20, 500);
      else dur = $urandom_range(500, 5000);
      pll_locked = lvl[0];
      for (int i = 0; i < dur; i++) begin
        soft_rst  = ($urandom_range(0, 299) == 0);
        fault_clr = ($urandom_range(0, 49) == 0);
        step();
      end
      soft_rst  = 1'b0;
      fault_clr = 1'b0;
      total += dur;
      if ($urandom_range(0, 24) == 0) begin
        do_reset();
        total += 4;
      end
    end

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
